instr_encoder: RTL and testbench
================================

# instr_encoder

Program-loader encoder for the single-cycle RV32I core: the inverse of the control/immediate decode path. It accepts field-level instruction requests (kind, func3, register indices, immediate) over a valid/ready handshake and encodes each into a 32-bit RV32I word. It writes the words sequentially into instruction memory and holds the core in reset until the program is complete. It is used by benches and boot logic to build programs without hand-assembled hex.

## Interface
- DEPTH, 64: instruction memory capacity in words; power of two, ≥ 2.
- AW, $clog2(DEPTH): word-index width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins a new load session.
- finish  in  1  pulse; ends the session.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid & ready.
- req_kind  in  3  0 LOAD, 1 ALU-I, 2 STORE, 3 R-type, 4 BRANCH, 5 JAL, 6 LUI, 7 AUIPC.
- req_func3  in  3  func3 field; ignored for kinds 5–7.
- req_alt  in  1  func7[5]: SUB/SRA for R-type, SRAI for ALU-I shifts.
- req_rd, req_rs1, req_rs2  in  5 each  register indices; unused fields are forced to 0.
- req_imm  in  32  immediate; byte offset for BRANCH/JAL, full value for LUI/AUIPC.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  32  byte address = word index × 4.
- mem_wdata  out  32  encoded instruction.
- count  out  AW+1  words written this session.
- cpu_hold  out  1  core reset request.
- done  out  1  session complete.
- err_overflow  out  1  sticky; a request was presented while memory was full.

## Operation
- FSM states: IDLE, LOAD, DONE. Reset state is IDLE.
- IDLE → LOAD on start.
- LOAD → DONE on the cycle after finish, with the pipeline empty.
- DONE → LOAD on start.
- start in any state:
  - count, write pointer and err_overflow clear to 0.
  - An unwritten pipeline entry is discarded.
  - start has priority over finish and over request acceptance in the same cycle.
- req_ready = (state == LOAD) & (count + pending < DEPTH) & !finish_seen.
- Accepted request: encoded into a pipeline register; written on the next cycle.
- Encodings, with op = opcode and bit slices of req_imm:
  - LOAD: imm[11:0] | rs1 | f3 | rd | 0000011.
  - ALU-I: imm[11:0] | rs1 | f3 | rd | 0010011.
    - For f3 001/101 only, bits [31:25] = {0, alt, 00000} and [24:20] = imm[4:0].
  - STORE: imm[11:5] | rs2 | rs1 | f3 | imm[4:0] | 0100011.
  - R-type: {0, alt, 00000} | rs2 | rs1 | f3 | rd | 0110011.
  - BRANCH: imm[12] | imm[10:5] | rs2 | rs1 | f3 | imm[4:1] | imm[11] | 1100011. imm[0] is ignored.
  - JAL: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | 1101111. imm[0] is ignored.
  - LUI / AUIPC: imm[31:12] | rd | 0110111 / 0010111. imm[11:0] is ignored.
- Write side:
  - mem_addr = ptr × 4.
  - ptr and count increment after each write.
  - ptr never wraps. A full memory stalls acceptance; it does not overwrite.
- Overflow: req_valid in LOAD with count + pending == DEPTH sets err_overflow. The request is not accepted.
- finish in LOAD:
  - Latched.
  - A request accepted in the same cycle is still written.
  - DONE is entered the cycle after the last write. If nothing is pending, DONE is entered the cycle after finish.
- finish outside LOAD is ignored.
- cpu_hold = 1 in IDLE and LOAD, 0 in DONE.
- done = 1 only in DONE.

## Timing
- Reset values:
  - state IDLE.
  - mem_we 0, mem_addr 0, mem_wdata 0.
  - count 0, done 0, err_overflow 0.
  - cpu_hold 1, req_ready 0.
- Latency: a request accepted at edge N produces mem_we = 1 with its data and address in cycle N+1. Throughput is one word per cycle.
- mem_we is high for exactly one cycle per accepted request. mem_addr and mem_wdata hold their last values when mem_we = 0.
- count updates on the same edge that ends the write cycle.
- Reset mid-session aborts immediately: no further writes, and all outputs return to their reset values.

## Test plan
- addi x1,x0,5 (kind 1, f3 000, rd 1, imm 5) → mem_wdata 0x00500093 at addr 0, one cycle after accept; count = 1.
- sub x3,x1,x2 (kind 3, alt 1) then sw x2,8(x1) (kind 2, f3 010) back-to-back → 0x402081B3 @0, 0x0020A423 @4 on consecutive cycles.
- beq x1,x2,-4 → 0xFE208EE3. jal x1,8 → 0x008000EF. lui x5,0x12345000 → 0x123452B7.
- DEPTH=4, five consecutive requests:
  - Four writes at 0x0, 0x4, 0x8, 0xC.
  - req_ready low on the fifth; err_overflow = 1; no fifth write.
- finish in the same cycle as an accepted request → that word is written, done and cpu_hold = 0 the following cycle.
- start mid-load with a pending entry → no write, count 0, next request written at addr 0. Assert rst_n = 0 mid-session → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/instr_encoder.sv
// Program-loader encoder: turns field-level RV32I instruction requests into
// 32-bit words and writes them sequentially into instruction memory.
module instr_encoder #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          finish,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_kind,
    input  logic [2:0]    req_func3,
    input  logic          req_alt,
    input  logic [4:0]    req_rd,
    input  logic [4:0]    req_rs1,
    input  logic [4:0]    req_rs2,
    input  logic [31:0]   req_imm,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [AW:0]   count,
    output logic          cpu_hold,
    output logic          done,
    output logic          err_overflow
);

    localparam int unsigned FW = AW + 2;

    localparam logic [2:0] KIND_LOAD   = 3'd0;
    localparam logic [2:0] KIND_ALUI   = 3'd1;
    localparam logic [2:0] KIND_STORE  = 3'd2;
    localparam logic [2:0] KIND_RTYPE  = 3'd3;
    localparam logic [2:0] KIND_BRANCH = 3'd4;
    localparam logic [2:0] KIND_JAL    = 3'd5;
    localparam logic [2:0] KIND_LUI    = 3'd6;
    localparam logic [2:0] KIND_AUIPC  = 3'd7;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } state_t;

    // Field-level request to RV32I word; fields a format does not use never reach the word.
    function automatic logic [31:0] encode(
        input logic [2:0]  kind,
        input logic [2:0]  f3,
        input logic        alt,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [31:0] imm
    );
        logic [31:0] w;
        w = '0;
        case (kind)
            KIND_LOAD:   w = {imm[11:0], rs1, f3, rd, OP_LOAD};
            KIND_ALUI: begin
                if (f3[1:0] == 2'b01)
                    w = {1'b0, alt, 5'b00000, imm[4:0], rs1, f3, rd, OP_ALUI};
                else
                    w = {imm[11:0], rs1, f3, rd, OP_ALUI};
            end
            KIND_STORE:  w = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
            KIND_RTYPE:  w = {1'b0, alt, 5'b00000, rs2, rs1, f3, rd, OP_RTYPE};
            KIND_BRANCH: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
            KIND_JAL:    w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            KIND_LUI:    w = {imm[31:12], rd, OP_LUI};
            KIND_AUIPC:  w = {imm[31:12], rd, OP_AUIPC};
        endcase
        return w;
    endfunction

    state_t      state, state_nxt;
    logic        finish_seen, finish_seen_nxt;
    logic [AW:0] count_nxt;
    logic        mem_we_nxt;
    logic [31:0] mem_addr_nxt;
    logic [31:0] mem_wdata_nxt;
    logic        req_ready_nxt;
    logic        cpu_hold_nxt;
    logic        done_nxt;
    logic        err_overflow_nxt;
    logic        accept;
    logic [FW-1:0] fill;
    logic [FW-1:0] fill_nxt;

    // Words committed plus the one currently on the write port.
    assign fill   = FW'(count) + FW'(mem_we);
    assign accept = req_valid & req_ready & ~start;

    always_comb begin
        state_nxt        = state;
        finish_seen_nxt  = finish_seen;
        count_nxt        = count + (AW+1)'(mem_we);
        mem_we_nxt       = accept;
        mem_addr_nxt     = mem_addr;
        mem_wdata_nxt    = mem_wdata;
        err_overflow_nxt = err_overflow;

        if (accept) begin
            mem_addr_nxt  = {30'(fill[AW-1:0]), 2'b00};
            mem_wdata_nxt = encode(req_kind, req_func3, req_alt, req_rd,
                                   req_rs1, req_rs2, req_imm);
        end

        case (state)
            ST_LOAD: begin
                if (req_valid && (fill == FW'(DEPTH)))
                    err_overflow_nxt = 1'b1;
                if (finish)
                    finish_seen_nxt = 1'b1;
                // An in-flight write completes on this same edge, so only a fresh accept delays DONE.
                if ((finish || finish_seen) && !accept) begin
                    state_nxt       = ST_DONE;
                    finish_seen_nxt = 1'b0;
                end
            end
            default: ;
        endcase

        if (start) begin
            state_nxt        = ST_LOAD;
            finish_seen_nxt  = 1'b0;
            count_nxt        = '0;
            mem_we_nxt       = 1'b0;
            err_overflow_nxt = 1'b0;
        end

        fill_nxt      = FW'(count_nxt) + FW'(mem_we_nxt);
        req_ready_nxt = (state_nxt == ST_LOAD) && (fill_nxt < FW'(DEPTH)) && !finish_seen_nxt;
        cpu_hold_nxt  = (state_nxt != ST_DONE);
        done_nxt      = (state_nxt == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            finish_seen  <= 1'b0;
            count        <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            req_ready    <= 1'b0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            state        <= state_nxt;
            finish_seen  <= finish_seen_nxt;
            count        <= count_nxt;
            mem_we       <= mem_we_nxt;
            mem_addr     <= mem_addr_nxt;
            mem_wdata    <= mem_wdata_nxt;
            req_ready    <= req_ready_nxt;
            cpu_hold     <= cpu_hold_nxt;
            done         <= done_nxt;
            err_overflow <= err_overflow_nxt;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: table of encodings plus hand-written
// sequences for back-to-back, overflow, finish, restart and reset.
module tb_instr_encoder;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          finish;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_kind;
    logic [2:0]    req_func3;
    logic          req_alt;
    logic [4:0]    req_rd;
    logic [4:0]    req_rs1;
    logic [4:0]    req_rs2;
    logic [31:0]   req_imm;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   count;
    logic          cpu_hold;
    logic          done;
    logic          err_overflow;

    int n_checks = 0;
    int n_errors = 0;

    instr_encoder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .finish       (finish),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_kind     (req_kind),
        .req_func3    (req_func3),
        .req_alt      (req_alt),
        .req_rd       (req_rd),
        .req_rs1      (req_rs1),
        .req_rs2      (req_rs2),
        .req_imm      (req_imm),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .count        (count),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  kind;
        logic [2:0]  f3;
        logic        alt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] kind, input logic [2:0] f3, input logic alt,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] imm);
        req_valid = 1'b1;
        req_kind  = kind;
        req_func3 = f3;
        req_alt   = alt;
        req_rd    = rd;
        req_rs1   = rs1;
        req_rs2   = rs2;
        req_imm   = imm;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_we"},    32'(mem_we),       32'd0);
        check({tag, "_addr"},  mem_addr,          32'd0);
        check({tag, "_wdata"}, mem_wdata,         32'd0);
        check({tag, "_count"}, 32'(count),        32'd0);
        check({tag, "_done"},  32'(done),         32'd0);
        check({tag, "_err"},   32'(err_overflow), 32'd0);
        check({tag, "_hold"},  32'(cpu_hold),     32'd1);
        check({tag, "_ready"}, 32'(req_ready),    32'd0);
    endtask

    initial begin
        //               kind  f3    alt   rd     rs1    rs2    imm            expected
        vecs[0]  = '{3'd1, 3'd0, 1'b1, 5'd1,  5'd0,  5'd7,  32'h0000_0005, 32'h0050_0093}; // addi x1,x0,5
        vecs[1]  = '{3'd3, 3'd0, 1'b1, 5'd3,  5'd1,  5'd2,  32'h0000_FFFF, 32'h4020_81B3}; // sub x3,x1,x2
        vecs[2]  = '{3'd2, 3'd2, 1'b0, 5'd31, 5'd1,  5'd2,  32'h0000_0008, 32'h0020_A423}; // sw x2,8(x1)
        vecs[3]  = '{3'd4, 3'd0, 1'b0, 5'd9,  5'd1,  5'd2,  32'hFFFF_FFFD, 32'hFE20_8EE3}; // beq x1,x2,-4
        vecs[4]  = '{3'd5, 3'd7, 1'b1, 5'd1,  5'd3,  5'd4,  32'h0000_0009, 32'h0080_00EF}; // jal x1,8
        vecs[5]  = '{3'd6, 3'd5, 1'b0, 5'd5,  5'd6,  5'd7,  32'h1234_5ABC, 32'h1234_52B7}; // lui x5
        vecs[6]  = '{3'd1, 3'd5, 1'b1, 5'd1,  5'd2,  5'd0,  32'h0000_0003, 32'h4031_5093}; // srai x1,x2,3
        vecs[7]  = '{3'd0, 3'd2, 1'b0, 5'd5,  5'd2,  5'd9,  32'hFFFF_FFF8, 32'hFF81_2283}; // lw x5,-8(x2)
        vecs[8]  = '{3'd7, 3'd0, 1'b0, 5'd10, 5'd0,  5'd0,  32'hABCD_E123, 32'hABCD_E517}; // auipc x10
        vecs[9]  = '{3'd1, 3'd1, 1'b0, 5'd4,  5'd4,  5'd0,  32'h0000_0FE5, 32'h0052_1213}; // slli x4,x4,5
        vecs[10] = '{3'd5, 3'd0, 1'b0, 5'd0,  5'd0,  5'd0,  32'hFFFF_F800, 32'h801F_F06F}; // jal x0,-2048

        rst_n = 1'b0; start = 1'b0; finish = 1'b0;
        set_req(3'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        req_valid = 1'b0;
        #12;
        check_reset_values("reset");
        rst_n = 1'b1;
        tick();
        check("idle_ready", 32'(req_ready), 32'd0);

        // One request per session: encode, latency, address and count.
        foreach (vecs[i]) begin
            pulse_start();
            check($sformatf("v%0d_ready", i), 32'(req_ready), 32'd1);
            set_req(vecs[i].kind, vecs[i].f3, vecs[i].alt, vecs[i].rd,
                    vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            tick();
            req_valid = 1'b0;
            check($sformatf("v%0d_we", i),    32'(mem_we), 32'd1);
            check($sformatf("v%0d_addr", i),  mem_addr,    32'd0);
            check($sformatf("v%0d_wdata", i), mem_wdata,   vecs[i].exp);
            tick();
            check($sformatf("v%0d_we_off", i), 32'(mem_we), 32'd0);
            check($sformatf("v%0d_count", i),  32'(count),  32'd1);
        end

        // Back-to-back: sub then sw on consecutive cycles.
        pulse_start();
        set_req(3'd3, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
        tick();
        check("b2b0_we",    32'(mem_we), 32'd1);
        check("b2b0_addr",  mem_addr,    32'h0);
        check("b2b0_wdata", mem_wdata,   32'h4020_81B3);
        set_req(3'd2, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
        tick();
        req_valid = 1'b0;
        check("b2b1_we",    32'(mem_we), 32'd1);
        check("b2b1_addr",  mem_addr,    32'h4);
        check("b2b1_wdata", mem_wdata,   32'h0020_A423);
        check("b2b1_count", 32'(count),  32'd1);
        tick();
        check("b2b_idle_we",   32'(mem_we), 32'd0);
        check("b2b_hold_addr", mem_addr,    32'h4);
        check("b2b_hold_data", mem_wdata,   32'h0020_A423);
        check("b2b_count",     32'(count),  32'd2);

        // Fill the 4-word memory with five requests; fifth must stall and flag overflow.
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            set_req(3'd1, 3'd0, 1'b0, 5'(k + 1), 5'd0, 5'd0, 32'(k));
            tick();
            check($sformatf("ovf_we%0d", k),   32'(mem_we), 32'd1);
            check($sformatf("ovf_addr%0d", k), mem_addr,    32'(k * 4));
            check($sformatf("ovf_data%0d", k), mem_wdata,   {12'(k), 5'd0, 3'd0, 5'(k + 1), 7'b0010011});
        end
        check("ovf_ready_low", 32'(req_ready),    32'd0);
        check("ovf_err_pre",   32'(err_overflow), 32'd0);
        set_req(3'd6, 3'd0, 1'b0, 5'd9, 5'd0, 5'd0, 32'hDEAD_B000);
        tick();
        check("ovf_no_5th_we", 32'(mem_we),       32'd0);
        check("ovf_err",       32'(err_overflow), 32'd1);
        check("ovf_count",     32'(count),        32'd4);
        tick();
        req_valid = 1'b0;
        check("ovf_no_5th_we2", 32'(mem_we),       32'd0);
        check("ovf_err_sticky", 32'(err_overflow), 32'd1);
        check("ovf_hold_addr",  mem_addr,          32'hC);

        // Restart with a request offered in the start cycle: discarded, state cleared.
        set_req(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rst_sess_we",    32'(mem_we),       32'd0);
        check("rst_sess_count", 32'(count),        32'd0);
        check("rst_sess_err",   32'(err_overflow), 32'd0);
        check("rst_sess_ready", 32'(req_ready),    32'd1);
        tick();
        req_valid = 1'b0;
        check("rst_sess_addr",  mem_addr,  32'h0);
        check("rst_sess_data",  mem_wdata, 32'h0050_0093);
        // Restart while a word is on the write port: it is not counted.
        set_req(3'd6, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("mid_start_we",    32'(mem_we), 32'd0);
        check("mid_start_count", 32'(count),  32'd0);
        tick();
        req_valid = 1'b0;
        check("mid_start_addr",  mem_addr,    32'h0);
        check("mid_start_data",  mem_wdata,   32'h1234_52B7);

        // Finish together with an accepted request.
        pulse_start();
        set_req(3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        req_valid = 1'b0;
        check("fin_we",    32'(mem_we),    32'd1);
        check("fin_data",  mem_wdata,      32'h0080_00EF);
        check("fin_done0", 32'(done),      32'd0);
        check("fin_hold0", 32'(cpu_hold),  32'd1);
        check("fin_ready", 32'(req_ready), 32'd0);
        tick();
        check("fin_done1", 32'(done),      32'd1);
        check("fin_hold1", 32'(cpu_hold),  32'd0);
        check("fin_we_off", 32'(mem_we),   32'd0);
        check("fin_count", 32'(count),     32'd1);

        // Finish with nothing pending, then restart from DONE.
        pulse_start();
        check("restart_hold", 32'(cpu_hold), 32'd1);
        check("restart_done", 32'(done),     32'd0);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        check("fin_empty_done", 32'(done),     32'd1);
        check("fin_empty_hold", 32'(cpu_hold), 32'd0);
        check("fin_empty_cnt",  32'(count),    32'd0);

        // Asynchronous reset in the middle of a write.
        pulse_start();
        set_req(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        tick();
        check("pre_rst_we", 32'(mem_we), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        tick();
        check("rst_hold_we", 32'(mem_we), 32'd0);
        req_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", 32'(req_ready), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
